// File: rtl/ex_muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_ctrl_if
// Description : EX-stage request/result bundle between the pipeline and the
//               iterative multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_muldiv_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             stall;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   // Pipeline side issues requests and consumes HI/LO and the stall.
   modport master (
      output start, op, rs_val, rt_val,
      input  stall, busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, rs_val, rt_val,
      output stall, busy, done, hi, lo, div_by_zero
   );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_ctrl
// Description : Iterative unsigned MULTU/DIVU sequencer (shift-add multiply,
//               restoring divide) driving HI/LO and the pipeline stall.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  wire logic            clk,
   input  wire logic            reset,
   ex_muldiv_ctrl_if.slave      bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               op_q;
   // a: acc / rem, b: mplier / quo, m: mcand / dvsr
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   m_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;
   logic               dbz_q;

   logic [WIDTH-1:0]   a_d;
   logic [WIDTH-1:0]   b_d;
   logic [WIDTH:0]     mul_sum_d;
   logic [WIDTH:0]     div_t_d;
   logic [WIDTH:0]     div_diff_d;
   logic               div_ge_d;
   logic               last_iter_d;

   // One iteration of the shared datapath; both results are WIDTH+1 wide so
   // the multiply carry and the divide partial remainder MSB are never lost.
   always_comb begin
      a_d        = '0;
      b_d        = '0;
      mul_sum_d  = {1'b0, a_q} + (b_q[0] ? {1'b0, m_q} : '0);
      div_t_d    = {a_q, b_q[WIDTH-1]};
      div_diff_d = div_t_d - {1'b0, m_q};
      div_ge_d   = (div_t_d >= {1'b0, m_q});
      if (!op_q) begin
         a_d = mul_sum_d[WIDTH:1];
         b_d = {mul_sum_d[0], b_q[WIDTH-1:1]};
      end else begin
         a_d = div_ge_d ? div_diff_d[WIDTH-1:0] : div_t_d[WIDTH-1:0];
         b_d = {b_q[WIDTH-2:0], div_ge_d};
      end
   end

   assign last_iter_d = (cnt_q == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         m_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  op_q    <= bus.op;
                  cnt_q   <= CNT_W'(WIDTH);
                  a_q     <= '0;
                  b_q     <= bus.rs_val;
                  m_q     <= bus.rt_val;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               a_q   <= a_d;
               b_q   <= b_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (last_iter_d) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  hi_q    <= a_d;
                  lo_q    <= b_d;
                  if (op_q) begin
                     dbz_q <= (m_q == '0);
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Stall is asserted in the request cycle itself so ID/EX holds the operands.
   assign bus.stall       = (state_q == S_RUN) | ((state_q == S_IDLE) & bus.start);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = done_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_ctrl
// Description : Directed scoreboard bench for the MULTU/DIVU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_ctrl;

   localparam int WIDTH = 32;

   typedef struct {
      logic [WIDTH-1:0] hi;
      logic [WIDTH-1:0] lo;
      logic             dbz;
   } exp_t;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   logic dbz_model;
   exp_t sb[$];

   ex_muldiv_ctrl_if #(.WIDTH(WIDTH)) bif ();

   ex_muldiv_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, optionally pulse a stray start at edge inject_at,
   // then wait for done and compare against the scoreboard head.
   task automatic run_op(input string name, input logic op, input logic [WIDTH-1:0] rs,
                         input logic [WIDTH-1:0] rt, input int inject_at);
      exp_t        e;
      logic [63:0] p;
      int          lat;
      logic        hold_ok;
      bif.start  = 1'b1;
      bif.op     = op;
      bif.rs_val = rs;
      bif.rt_val = rt;
      #1;
      chk({name, "_stall_req"}, 64'(bif.stall), 64'd1);
      if (!op) begin
         p    = {32'd0, rs} * {32'd0, rt};
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (rt == '0) begin
         e.hi = rs;
         e.lo = '1;
      end else begin
         e.hi = rs % rt;
         e.lo = rs / rt;
      end
      if (op) dbz_model = (rt == '0);
      e.dbz = dbz_model;
      @(posedge clk);
      sb.push_back(e);
      #1;
      bif.start = 1'b0;
      lat       = 0;
      hold_ok   = 1'b1;
      while (!bif.done && lat < 64) begin
         if (!bif.stall || !bif.busy) hold_ok = 1'b0;
         if (inject_at > 0 && lat == inject_at - 1) begin
            bif.start  = 1'b1;
            bif.op     = 1'b1;
            bif.rs_val = 32'd50;
            bif.rt_val = 32'd5;
         end else begin
            bif.start = 1'b0;
         end
         tick();
         lat++;
      end
      bif.start = 1'b0;
      chk({name, "_latency"}, 64'(lat), 64'(WIDTH));
      chk({name, "_stall_held"}, 64'(hold_ok), 64'd1);
      chk({name, "_stall_in_done"}, 64'(bif.stall), 64'd0);
      chk({name, "_busy_in_done"}, 64'(bif.busy), 64'd1);
      if (sb.size() == 0) begin
         chk({name, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         chk({name, "_hi"}, 64'(bif.hi), 64'(e.hi));
         chk({name, "_lo"}, 64'(bif.lo), 64'(e.lo));
         chk({name, "_dbz"}, 64'(bif.div_by_zero), 64'(e.dbz));
      end
      tick();
      chk({name, "_done_fall"}, 64'(bif.done), 64'd0);
      chk({name, "_busy_fall"}, 64'(bif.busy), 64'd0);
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      dbz_model  = 1'b0;
      reset      = 1'b1;
      bif.start  = 1'b0;
      bif.op     = 1'b0;
      bif.rs_val = '0;
      bif.rt_val = '0;
      tick();
      tick();
      chk("rst_busy", 64'(bif.busy), 64'd0);
      chk("rst_stall", 64'(bif.stall), 64'd0);
      chk("rst_done", 64'(bif.done), 64'd0);
      chk("rst_hi", 64'(bif.hi), 64'd0);
      chk("rst_lo", 64'(bif.lo), 64'd0);
      chk("rst_dbz", 64'(bif.div_by_zero), 64'd0);
      reset = 1'b0;
      tick();

      run_op("mul_7x6", 1'b0, 32'd7, 32'd6, 0);
      run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("div_100_7", 1'b1, 32'd100, 32'd7, 0);
      run_op("div_5_0", 1'b1, 32'd5, 32'd0, 0);
      run_op("mul_keep_dbz", 1'b0, 32'h0001_0000, 32'h0001_0000, 0);
      run_op("div_9_3", 1'b1, 32'd9, 32'd3, 0);
      run_op("div_bigdvsr", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0);

      // Stray DIVU at E10 must be ignored; the next request follows directly.
      run_op("mul_3x4_ign", 1'b0, 32'd3, 32'd4, 10);
      run_op("b2b_div", 1'b1, 32'd77, 32'd8, 0);

      // Reset arriving mid-divide abandons it without a done pulse.
      bif.start  = 1'b1;
      bif.op     = 1'b1;
      bif.rs_val = 32'd1000;
      bif.rt_val = 32'd10;
      tick();
      bif.start = 1'b0;
      for (int i = 1; i < 15; i++) tick();
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      dbz_model = 1'b0;
      chk("midrst_stall", 64'(bif.stall), 64'd0);
      chk("midrst_busy", 64'(bif.busy), 64'd0);
      chk("midrst_done", 64'(bif.done), 64'd0);
      chk("midrst_hi", 64'(bif.hi), 64'd0);
      chk("midrst_lo", 64'(bif.lo), 64'd0);
      begin
         int dones = 0;
         for (int i = 0; i < 40; i++) begin
            tick();
            if (bif.done) dones++;
         end
         chk("midrst_no_done", 64'(dones), 64'd0);
      end
      run_op("mul_2x3", 1'b0, 32'd2, 32'd3, 0);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
